seg7_scroll_animator: RTL and testbench

SEG7_SCROLL_ANIMATOR -- requirements
Module: seg7_scroll_animator

---
 rtl/seg7_scroll_animator_if.sv | 10 +
 rtl/seg7_scroll_animator.sv | 136 +++++++++++++
 tb/tb_seg7_scroll_animator.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scroll_animator_if.sv
// Character push channel: valid/ready handshake carrying one 7-segment pattern {g,f,e,d,c,b,a}.
// Producer drives valid/data; the animator returns ready (FIFO not full, combinational).
interface seg7_scroll_animator_if;
    logic       char_valid;
    logic [6:0] char_in;
    logic       char_ready;

    modport master (output char_valid, output char_in, input  char_ready);
    modport slave  (input  char_valid, input  char_in, output char_ready);
endinterface

// File: rtl/seg7_scroll_animator.sv
// Multiplexed 7-seg scroller: char FIFO feeds a display buffer that shifts once per frame (SCROLL).
// Latency: push visible no earlier than next frame_tick; seg_out/digit_sel registered 1 cycle after mux index.
// Backpressure: char_ready = !full, pushes dropped when full. Optional blink mode via macro SEG7_BLINK_EN.
module seg7_scroll_animator #(
    parameter int NUM_DIGITS = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_DIV  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    seg7_scroll_animator_if.slave chr,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_tick
);
    localparam int CW = (FRAME_DIV  > 1) ? $clog2(FRAME_DIV)  : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SCROLL = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    mode_e                  mode_w;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [6:0]             seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  sel_q, sel_d;
    logic [6:0]             disp_q [NUM_DIGITS];
    logic [6:0]             disp_d [NUM_DIGITS];
    logic [6:0]             fifo_q [FIFO_DEPTH];
    logic [6:0]             fifo_d [FIFO_DEPTH];
    logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
    logic [OW-1:0]          occ_q, occ_d;
    logic                   full, push, pop, clr, blank;
`ifdef SEG7_BLINK_EN
    logic                   phase_q, phase_d;
`endif

    assign mode_w         = mode_e'(mode);
    assign full           = (occ_q == OW'(FIFO_DEPTH));
    assign chr.char_ready = !full;
    assign frame_tick     = enable && (cnt_q == CW'(FRAME_DIV - 1));
    // Pop decision uses pre-push occupancy so a same-cycle push into an empty FIFO waits a frame.
    assign pop            = frame_tick && (mode_w == MODE_SCROLL) && (occ_q != '0);
    assign clr            = frame_tick && (mode_w == MODE_CLEAR);
    assign push           = chr.char_valid && !full && !clr;
    assign seg_out        = seg_q;
    assign digit_sel      = sel_q;

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        seg_d  = seg_q;
        sel_d  = sel_q;
        disp_d = disp_q;
        fifo_d = fifo_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        occ_d  = occ_q;
`ifdef SEG7_BLINK_EN
        phase_d = phase_q;
        if (frame_tick) begin
            phase_d = (mode_w == MODE_BLINK) ? ~phase_q : 1'b0;
        end
        blank = phase_q;
`else
        blank = 1'b0;
`endif

        if (enable) begin
            cnt_d = (cnt_q == CW'(FRAME_DIV - 1)) ? '0 : cnt_q + 1'b1;
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            sel_d = NUM_DIGITS'(1) << idx_q;
            seg_d = blank ? 7'h00 : disp_q[idx_q];
        end

        if (clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) disp_d[i] = 7'h00;
            rd_d  = '0;
            wr_d  = '0;
            occ_d = '0;
        end else begin
            if (pop) begin
                for (int i = NUM_DIGITS - 1; i > 0; i--) disp_d[i] = disp_q[i-1];
                disp_d[0] = fifo_q[rd_q];
                rd_d      = rd_q + 1'b1;
            end
            if (push) begin
                fifo_d[wr_q] = chr.char_in;
                wr_d         = wr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            seg_q  <= 7'h00;
            sel_q  <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            occ_q  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) disp_q[i] <= 7'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 7'h00;
`ifdef SEG7_BLINK_EN
            phase_q <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            sel_q  <= sel_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            occ_q  <= occ_d;
            disp_q <= disp_d;
            fifo_q <= fifo_d;
`ifdef SEG7_BLINK_EN
            phase_q <= phase_d;
`endif
        end
    end
endmodule

// File: tb/tb_seg7_scroll_animator.sv
// Bench for seg7_scroll_animator (default build): directed scenarios plus random traffic,
// expected outputs queued per cycle from a queue/array model and checked by an independent monitor.
module tb_seg7_scroll_animator;
    localparam int ND = 4;
    localparam int FD = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [6:0] seg_out;
    logic [ND-1:0] digit_sel;
    logic       frame_tick;

    seg7_scroll_animator_if cif ();

    seg7_scroll_animator #(.NUM_DIGITS(ND), .FIFO_DEPTH(DEPTH), .FRAME_DIV(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .chr        (cif),
        .seg_out    (seg_out),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ft;
        logic          rdy;
        logic [6:0]    seg;
        logic [ND-1:0] sel;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc_no = 0;
    bit   done = 0;

    // Reference model: pending characters as a queue, digits as an array, counters as plain integers.
    logic [6:0]    m_fifo[$];
    logic [6:0]    m_disp[ND];
    int            m_frame;
    int            m_scan;
    logic [6:0]    m_seg;
    logic [ND-1:0] m_sel;

    task automatic model_reset();
        m_fifo.delete();
        foreach (m_disp[i]) m_disp[i] = 7'h00;
        m_frame = 0;
        m_scan  = 0;
        m_seg   = 7'h00;
        m_sel   = '0;
    endtask

    task automatic cyc(input bit r, input bit en, input bit v, input logic [6:0] ch, input logic [1:0] md);
        exp_t e;
        bit   tick, rdy;
        logic [6:0] head;
        @(posedge clk);
        #2;
        reset = r; enable = en; cif.char_valid = v; cif.char_in = ch; mode = md;
        if (r) begin
            model_reset();
            e.ft = 1'b0; e.rdy = 1'b1; e.seg = 7'h00; e.sel = '0;
            expq.push_back(e);
            return;
        end
        tick = en && (m_frame == FD - 1);
        rdy  = (m_fifo.size() < DEPTH);
        e.ft = tick; e.rdy = rdy; e.seg = m_seg; e.sel = m_sel;
        expq.push_back(e);
        if (en) begin
            m_seg   = m_disp[m_scan];
            m_sel   = ND'(1) << m_scan;
            m_scan  = (m_scan + 1) % ND;
            m_frame = (m_frame + 1) % FD;
        end
        if (tick && md == 2'b11) begin
            foreach (m_disp[i]) m_disp[i] = 7'h00;
            m_fifo.delete();
        end else begin
            if (tick && md == 2'b01 && m_fifo.size() > 0) begin
                head = m_fifo.pop_front();
                for (int i = ND - 1; i > 0; i--) m_disp[i] = m_disp[i-1];
                m_disp[0] = head;
            end
            if (v && rdy) m_fifo.push_back(ch);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc_no, got, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #4;
            cyc_no++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("frame_tick", 32'(frame_tick),     32'(e.ft));
                chk("char_ready", 32'(cif.char_ready), 32'(e.rdy));
                chk("seg_out",    32'(seg_out),        32'(e.seg));
                chk("digit_sel",  32'(digit_sel),      32'(e.sel));
            end
        end
    end

    initial begin
        logic [1:0] md;
        cif.char_valid = 1'b0;
        cif.char_in    = 7'h00;
        model_reset();

        // reset, then idle: tick cadence and scan order
        repeat (2) cyc(1, 1, 0, 7'h00, 2'b00);
        repeat (10) cyc(0, 1, 0, 7'h00, 2'b00);
        // two chars scroll in
        cyc(0, 1, 1, 7'h06, 2'b01);
        cyc(0, 1, 1, 7'h5B, 2'b01);
        repeat (14) cyc(0, 1, 0, 7'h00, 2'b01);
        // overfill in HOLD, then scroll out exactly four
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 7'(7'h10 + i), 2'b00);
        repeat (20) cyc(0, 1, 0, 7'h00, 2'b01);
        // full FIFO then CLEAR
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 7'(7'h21 + i), 2'b00);
        cyc(0, 1, 1, 7'h7F, 2'b00);
        repeat (8) cyc(0, 1, 1, 7'h55, 2'b11);
        // reload, then BLINK behaves as HOLD without the macro
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 7'(7'h31 + i), 2'b01);
        repeat (16) cyc(0, 1, 0, 7'h00, 2'b01);
        repeat (16) cyc(0, 1, 0, 7'h00, 2'b10);
        // enable low freezes everything
        repeat (6) cyc(0, 0, 0, 7'h00, 2'b01);
        // mid-frame reset with two chars queued
        cyc(0, 1, 1, 7'h4F, 2'b00);
        cyc(0, 1, 1, 7'h66, 2'b00);
        cyc(0, 1, 0, 7'h00, 2'b00);
        repeat (2) cyc(1, 1, 1, 7'h7F, 2'b01);
        repeat (10) cyc(0, 1, 0, 7'h00, 2'b01);

        md = 2'b01;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 8,
                $urandom_range(0, 1) == 1, 7'($urandom), md);
        end

        repeat (3) @(posedge clk);
        #5;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain leftover=%0d expected=0", expq.size());
        end
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        if (!done) begin
            $display("FAIL timeout total=%0d", total);
            $fatal(1, "timeout");
        end
    end
endmodule
